// File: rtl/model_stream_rx_if.sv
// -----------------------------------------------------------------------------
// model_stream_rx_if
//   Stream bundle for model_stream_rx. It groups two streams:
//     - the upstream valid-only beat stream (i_VALID / i_DATA, no ready)
//     - the downstream valid/ready stream (o_VALID / o_DATA / i_READY)
//   The signal names are written from the receiver's point of view.
//
//   Modports:
//     slave  : receiver side (model_stream_rx)
//     master : producer/consumer side (testbench or surrounding top)
//
//   Handshake: a downstream beat transfers on a rising edge where o_VALID and
//   i_READY are both high. Once o_VALID rises, it stays high with stable o_DATA
//   until that transfer happens. i_READY may be high while o_VALID is low, and
//   nothing transfers then. The upstream stream cannot be stalled.
// -----------------------------------------------------------------------------
interface model_stream_rx_if #(
   parameter int BITWIDTH = 16
);
   logic                i_VALID;
   logic [BITWIDTH-1:0] i_DATA;
   logic                o_VALID;
   logic [BITWIDTH-1:0] o_DATA;
   logic                i_READY;

   modport slave (
      input  i_VALID,
      input  i_DATA,
      input  i_READY,
      output o_VALID,
      output o_DATA
   );

   modport master (
      output i_VALID,
      output i_DATA,
      output i_READY,
      input  o_VALID,
      input  o_DATA
   );
endinterface

// File: rtl/model_stream_rx.sv
// -----------------------------------------------------------------------------
// model_stream_rx
//   Receives a valid-only beat stream, for example MODEL o_VALID/o_DATA.
//   Every beat is stored in a DEPTH-entry first-word-fall-through FIFO, and
//   the FIFO presents the beats downstream on a valid/ready handshake. The
//   producer cannot be stalled, so a beat that arrives while the FIFO is full
//   and nothing is popped is dropped. Each drop is flagged and counted.
//
//   Ports:
//     i_CLK       clock, every register updates on the rising edge
//     i_nRST      synchronous active-low reset
//     s_if        stream bundle (slave modport):
//                   i_VALID/i_DATA  upstream beat
//                   o_VALID/o_DATA  downstream beat (head of the FIFO)
//                   i_READY         downstream ready
//     o_LEVEL     current occupancy, 0..DEPTH
//     o_FULL      high when level == DEPTH
//     o_EMPTY     high when level == 0
//     o_OVERFLOW  sticky flag, set when a beat is dropped
//     o_DROP_CNT  saturating count of dropped beats
//     i_CLR_OVF   clears o_OVERFLOW and o_DROP_CNT. A drop in the same cycle wins.
// -----------------------------------------------------------------------------
module model_stream_rx #(
   parameter int BITWIDTH = 16,
   parameter int DEPTH    = 8,
   parameter int CNTW     = 16
) (
   input  logic                     i_CLK,
   input  logic                     i_nRST,
   model_stream_rx_if.slave         s_if,
   output logic [$clog2(DEPTH):0]   o_LEVEL,
   output logic                     o_FULL,
   output logic                     o_EMPTY,
   output logic                     o_OVERFLOW,
   output logic [CNTW-1:0]          o_DROP_CNT,
   input  logic                     i_CLR_OVF
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [BITWIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q,  level_d;
   logic            ovf_q,    ovf_d;
   logic [CNTW-1:0] cnt_q,    cnt_d;

   logic is_empty;
   logic is_full;
   logic pop;
   logic push;
   logic drop;

   assign is_empty = (level_q == '0);
   assign is_full  = (level_q == LW'(DEPTH));

   // A full FIFO can still accept a beat when a pop frees a slot in the same
   // cycle. An empty FIFO cannot pop, so no bypass path is needed.
   assign pop  = !is_empty && s_if.i_READY;
   assign push = s_if.i_VALID && (!is_full || pop);
   assign drop = s_if.i_VALID && is_full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;

      // The pointers wrap naturally at DEPTH, which is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // The clear is applied first, so a drop in the same cycle restarts the
      // count at 1 and leaves the flag set.
      if (i_CLR_OVF) begin
         ovf_d = 1'b0;
         cnt_d = '0;
      end
      if (drop) begin
         ovf_d = 1'b1;
         if (cnt_d != {CNTW{1'b1}}) cnt_d = cnt_d + CNTW'(1);
      end
   end

   always_ff @(posedge i_CLK) begin
      if (!i_nRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
      end
   end

   // The storage array has no reset. Stored beats become unreachable when the
   // pointers and the level clear. Writes are blocked during reset so that a
   // beat seen in the reset cycle is never captured.
   always_ff @(posedge i_CLK) begin
      if (i_nRST && push) mem_q[wr_ptr_q] <= s_if.i_DATA;
   end

   // Every output comes from registers only. o_DATA is forced to 0 while the
   // FIFO is empty, so it has a defined value after reset.
   assign s_if.o_VALID = !is_empty;
   assign s_if.o_DATA  = is_empty ? '0 : mem_q[rd_ptr_q];
   assign o_LEVEL      = level_q;
   assign o_FULL       = is_full;
   assign o_EMPTY      = is_empty;
   assign o_OVERFLOW   = ovf_q;
   assign o_DROP_CNT   = cnt_q;

endmodule

// File: tb/tb_model_stream_rx.sv
// -----------------------------------------------------------------------------
// tb_model_stream_rx
//   Directed bench for model_stream_rx with BITWIDTH=16, DEPTH=8, CNTW=16.
//   Each table record holds one cycle of inputs and the outputs expected just
//   after the rising edge. After the table, a fixed ready/valid pattern runs
//   against a reference queue to check ordering under back-pressure.
// -----------------------------------------------------------------------------
module tb_model_stream_rx;
   localparam int W = 16;
   localparam int D = 8;
   localparam int C = 16;

   logic         clk;
   logic         rst_n;
   logic         clr_ovf;
   logic [3:0]   level;
   logic         full;
   logic         empty;
   logic         ovf;
   logic [C-1:0] drop_cnt;

   model_stream_rx_if #(.BITWIDTH(W)) sif ();

   model_stream_rx #(.BITWIDTH(W), .DEPTH(D), .CNTW(C)) dut (
      .i_CLK      (clk),
      .i_nRST     (rst_n),
      .s_if       (sif.slave),
      .o_LEVEL    (level),
      .o_FULL     (full),
      .o_EMPTY    (empty),
      .o_OVERFLOW (ovf),
      .o_DROP_CNT (drop_cnt),
      .i_CLR_OVF  (clr_ovf)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         rst_n;
      logic         vld;
      logic [W-1:0] din;
      logic         rdy;
      logic         clr;
      logic [W-1:0] edata;
      logic [3:0]   elvl;
      logic         eovf;
      logic [C-1:0] ecnt;
   } vec_t;

   vec_t        vecs[$];
   logic [W-1:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic add(input logic r, input logic v, input logic [W-1:0] d,
                      input logic rd, input logic cl, input logic [W-1:0] ed,
                      input logic [3:0] el, input logic eo, input logic [C-1:0] ec);
      vec_t t;
      t.rst_n = r; t.vld = v; t.din = d; t.rdy = rd; t.clr = cl;
      t.edata = ed; t.elvl = el; t.eovf = eo; t.ecnt = ec;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] req);
      if (act !== req) begin
         n_err++;
         $display("FAIL %s @%0d: got 0x%0h, want 0x%0h", name, idx, act, req);
      end
   endtask

   // driver tasks
   task automatic drive(input logic r, input logic v, input logic [W-1:0] d,
                        input logic rd, input logic cl);
      rst_n = r; sif.i_VALID = v; sif.i_DATA = d; sif.i_READY = rd; clr_ovf = cl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // reset state, then a beat presented during reset that must not be captured
      add(0,0,16'h0000,0,0, 16'h0000,0,0,0);
      add(0,1,16'h1234,0,0, 16'h0000,0,0,0);
      // streaming with ready high: each beat shows one cycle after its push
      for (int i = 1; i <= 5; i++) add(1,1,W'(i),1,0, W'(i),1,0,0);
      add(1,0,16'h0000,1,0, 16'h0000,0,0,0);
      // fill with A0..A7 while ready is low
      for (int i = 0; i < 8; i++) add(1,1,W'(16'h00A0+i),0,0, 16'h00A0,4'(i+1),0,0);
      // three drops while full
      for (int i = 0; i < 3; i++) add(1,1,W'(16'h00B0+i),0,0, 16'h00A0,8,1,C'(i+1));
      // full: push FF and pop A0 in the same cycle
      add(1,1,16'h00FF,1,0, 16'h00A1,8,1,3);
      // drain A1..A7 and FF in order
      for (int i = 0; i < 6; i++) add(1,0,16'h0000,1,0, W'(16'h00A2+i),4'(7-i),1,3);
      add(1,0,16'h0000,1,0, 16'h00FF,1,1,3);
      add(1,0,16'h0000,1,0, 16'h0000,0,1,3);
      // ready high while empty has no effect
      add(1,0,16'h0000,1,0, 16'h0000,0,1,3);
      // fill with C0..C7
      for (int i = 0; i < 8; i++) add(1,1,W'(16'h00C0+i),0,0, 16'h00C0,4'(i+1),1,3);
      // clear together with a drop: the drop wins. Then a clear alone.
      add(1,1,16'h00D0,0,1, 16'h00C0,8,1,1);
      add(1,0,16'h0000,0,1, 16'h00C0,8,0,0);
      // one drop, then pops down to level 5
      add(1,1,16'h00D1,0,0, 16'h00C0,8,1,1);
      for (int i = 0; i < 3; i++) add(1,0,16'h0000,1,0, W'(16'h00C1+i),4'(7-i),1,1);
      // reset mid-stream with valid high
      add(0,1,16'h00EE,0,0, 16'h0000,0,0,0);
      add(1,1,16'h0077,0,0, 16'h0077,1,0,0);
      add(1,0,16'h0000,1,0, 16'h0000,0,0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].vld, vecs[i].din, vecs[i].rdy, vecs[i].clr);
         step();
         n_vec++;
         chk("level", i, 32'(level),        32'(vecs[i].elvl));
         chk("valid", i, 32'(sif.o_VALID),  32'(vecs[i].elvl != 0));
         chk("data",  i, 32'(sif.o_DATA),   32'(vecs[i].edata));
         chk("full",  i, 32'(full),         32'(vecs[i].elvl == 4'd8));
         chk("empty", i, 32'(empty),        32'(vecs[i].elvl == 4'd0));
         chk("ovf",   i, 32'(ovf),          32'(vecs[i].eovf));
         chk("cnt",   i, 32'(drop_cnt),     32'(vecs[i].ecnt));
      end

      // Back-pressure ordering: ready follows a fixed pattern, and the
      // reference queue models which beats are accepted and popped.
      exp_q.delete();
      for (int i = 0; i < 60; i++) begin
         logic v, r, pop_m;
         logic [W-1:0] d;
         v = (i % 4) != 3;
         r = (i % 5) > 2;
         d = W'(16'h0300 + i);
         drive(1'b1, v, d, r, 1'b0);
         pop_m = (exp_q.size() > 0) && r;
         if (exp_q.size() > 0) chk("seq_head", i, 32'(sif.o_DATA), 32'(exp_q[0]));
         if (pop_m) void'(exp_q.pop_front());
         if (v && (exp_q.size() < D)) exp_q.push_back(d);
         step();
         n_vec++;
         chk("seq_level", i, 32'(level), 32'(exp_q.size()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
